// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - top-of-stack cache and spill controller for a stack RAM
//
// Keeps top-of-stack (T) in a register and spills older entries into an
// external RAM that has a combinational read port. The second entry (N) is
// always the RAM word just below the spill pointer.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   op_valid, op_code        operation strobe; 00 nop, 01 push, 11 pop, 10 replace T
//   op_data                  value for push / replace
//   top, next                T (registered) and N (RAM read data, zero below depth 2)
//   depth, empty, full       occupancy, 0..2**DEPTH+1
//   overflow, underflow      sticky error flags, cleared only by reset
//   ram_read_*               RAM read port (combinational data return)
//   ram_write_*              RAM write port (lands on the rising edge)

`ifndef WIDTH
`define WIDTH 16
`endif

module stack_controller #(
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [1:0]         op_code,
    input  logic [`WIDTH-1:0]  op_data,
    output logic [`WIDTH-1:0]  top,
    output logic [`WIDTH-1:0]  next,
    output logic [DEPTH:0]     depth,
    output logic               empty,
    output logic               full,
    output logic               overflow,
    output logic               underflow,
    output logic [DEPTH-1:0]   ram_read_address,
    input  logic [`WIDTH-1:0]  ram_read_data,
    output logic               ram_write_enable,
    output logic [DEPTH-1:0]   ram_write_address,
    output logic [`WIDTH-1:0]  ram_write_data
);

    localparam int             CAPACITY = (1 << DEPTH) + 1;
    localparam logic [DEPTH:0] C_FULL   = (DEPTH+1)'(CAPACITY);
    localparam logic [DEPTH:0] C_ZERO   = '0;
    localparam logic [DEPTH:0] C_ONE    = (DEPTH+1)'(1);
    localparam logic [DEPTH:0] C_TWO    = (DEPTH+1)'(2);

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_PUSH    = 2'b01;
    localparam logic [1:0] OP_REPLACE = 2'b10;
    localparam logic [1:0] OP_POP     = 2'b11;

    logic [`WIDTH-1:0] t_reg, t_nxt;
    logic [DEPTH:0]    c_reg, c_nxt;
    logic              ovf_reg, ovf_nxt;
    logic              unf_reg, unf_nxt;
    logic              write_req;

    // Spill count w is c-1 (0 when empty). The write goes to w and N is read
    // from w-1, so the two ports never collide and no bypass is needed.
    // At c<=1 the read address wraps to all-ones; next is gated off there.
    assign ram_write_address = DEPTH'(c_reg - C_ONE);
    assign ram_read_address  = (c_reg == C_ZERO) ? '1 : DEPTH'(c_reg - C_TWO);
    assign ram_write_data    = t_reg;

    // Reset wins over a same-cycle push, including its RAM write.
    assign ram_write_enable  = write_req & ~reset;

    always_comb begin
        t_nxt     = t_reg;
        c_nxt     = c_reg;
        ovf_nxt   = ovf_reg;
        unf_nxt   = unf_reg;
        write_req = 1'b0;
        if (op_valid) begin
            case (op_code)
                OP_PUSH: begin
                    if (c_reg == C_ZERO) begin
                        t_nxt = op_data;
                        c_nxt = C_ONE;
                    end else if (c_reg == C_FULL) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        // Old T spills to the RAM as the new T is captured.
                        write_req = 1'b1;
                        t_nxt     = op_data;
                        c_nxt     = c_reg + C_ONE;
                    end
                end
                OP_POP: begin
                    if (c_reg == C_ZERO) begin
                        unf_nxt = 1'b1;
                    end else if (c_reg == C_ONE) begin
                        t_nxt = '0;
                        c_nxt = C_ZERO;
                    end else begin
                        // N becomes the new T; its RAM slot is simply abandoned.
                        t_nxt = ram_read_data;
                        c_nxt = c_reg - C_ONE;
                    end
                end
                OP_REPLACE: begin
                    if (c_reg == C_ZERO) begin
                        unf_nxt = 1'b1;
                    end else begin
                        t_nxt = op_data;
                    end
                end
                OP_NOP: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            t_reg   <= '0;
            c_reg   <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            t_reg   <= t_nxt;
            c_reg   <= c_nxt;
            ovf_reg <= ovf_nxt;
            unf_reg <= unf_nxt;
        end
    end

    assign top       = t_reg;
    assign next      = (c_reg >= C_TWO) ? ram_read_data : '0;
    assign depth     = c_reg;
    assign empty     = (c_reg == C_ZERO);
    assign full      = (c_reg == C_FULL);
    assign overflow  = ovf_reg;
    assign underflow = unf_reg;

endmodule
